uart_rx_bg: RTL and testbench
=============================

Name: uart_rx_bg

Overview:
- UART receiver with integrated baud-rate tick generator. It is the downstream consumer of the serial line driven by tx_bg_top's o_tx.
- Recovers 8N1 frames using 16x oversampling with mid-bit sampling. Presents each received byte with a one-cycle done strobe and a framing-error flag.
- Used standalone on the board RX pin and in tx→rx loopback benches.

Parameters:
- DBIT, 8: data bits per frame, LSB first.
- SB_TICK, 16: oversample ticks for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- NB_STATE, 2: FSM state register width.
- BAUD_DIV, 163: clock cycles per oversample tick. 50 MHz / (19200 × 16) = 162.76, rounded to 163.
- NB_DIV, 8: width of the baud divider counter; must satisfy 2^NB_DIV ≥ BAUD_DIV.

Ports:
- i_clock  in  1  system clock, 50 MHz.
- i_reset  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial input; idles high.
- o_rx_data  out  DBIT  last received byte; holds its value until the next completed frame.
- o_rx_done_tick  out  1  one-cycle pulse when a frame completes; o_rx_data is valid in the same cycle.
- o_frame_err  out  1  stop-bit sample of the last frame was 0; updated together with o_rx_done_tick.

Behaviour:
- Clock/reset: one clock domain. Reset is synchronous and active-high on i_reset, sampled at the rising edge of i_clock.
- Reset values:
  - state = IDLE; s = 0; n = 0; shift register = 0.
  - o_rx_data = 0; o_rx_done_tick = 0; o_frame_err = 0.
  - Baud counter = 0; both synchronizer flops = 1 (line idle).
- Input synchronizer: two flops on i_rx, giving rx_s. The FSM uses rx_s only, adding 2 cycles of input latency.
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1.
  - tick = 1 for exactly one cycle when counter == BAUD_DIV-1, then the counter wraps to 0.
  - The counter is not re-synchronised to frame start.
- FSM, with s = oversample counter (4 bits, sized for SB_TICK) and n = bit counter:
  - IDLE: if rx_s == 0, go to START with s = 0. No tick is required to leave IDLE.
  - START: on tick:
    - if s == 7 and rx_s == 0, go to DATA with s = 0, n = 0;
    - if s == 7 and rx_s == 1, return to IDLE (glitch rejected, no output change);
    - otherwise s++.
  - DATA: on tick:
    - if s == 15, set s = 0 and shift {rx_s, b[DBIT-1:1]}; then go to STOP if n == DBIT-1, else n++;
    - otherwise s++.
  - STOP: on tick:
    - if s == SB_TICK-1, go to IDLE and in the next cycle assert o_rx_done_tick, load o_rx_data = b and o_frame_err = ~rx_s;
    - otherwise s++.
- Done strobe: o_rx_done_tick is high for exactly one i_clock cycle per frame, never on a rejected start.
- Back-to-back frames: after STOP the FSM returns to IDLE. A start bit already low at that point is accepted immediately, with no gap required.
- Break condition (line held low): each 10-bit period yields a done pulse with data 0 and o_frame_err = 1. This is the decided behaviour; no break detection.
- Reset mid-frame: abort immediately to reset values. No done pulse for the partial frame.
- Tick and state change in the same cycle: the state register and counters update once per tick; between ticks the FSM holds, except for the IDLE→START transition.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11;
  - defaults for DBIT, SB_TICK, NB_STATE, BAUD_DIV;
  - derived constant OVERSAMPLE = 16.
- One sub-module, baud_rate_gen (parameters BAUD_DIV, NB_DIV; ports i_clock, i_reset, o_tick). The identical generator is instantiated by tx_bg_top.
- The RX FSM, synchronizer and output registers live in uart_rx_bg itself.

Test Plan:
- Nominal frame: bit time 52160 ns. Drive 0xAA (start 0, bits 0,1,0,1,0,1,0,1, stop 1) after 2 µs idle → one o_rx_done_tick pulse, o_rx_data = 8'hAA, o_frame_err = 0.
- Loopback: tx_bg_top.o_tx → i_rx, i_data = 8'b10101010, i_tx_start pulsed → o_rx_done_tick within 11 bit times of the tx start, o_rx_data = 8'hAA, o_frame_err = 0.
- Glitch rejection: i_rx low for 10000 ns (< half bit, 26080 ns), then high → FSM returns to IDLE, no done pulse, o_rx_data unchanged.
- Framing error: send 0x55 with the stop bit driven 0 → done pulse, o_rx_data = 8'h55, o_frame_err = 1. A following valid frame 0x0F gives o_frame_err = 0.
- Reset mid-frame: assert i_reset for 2 cycles during data bit 3 of a 0xC3 frame → outputs 0, no done pulse. The next frame 0x3C is received correctly.
- Back-to-back: frames 0x01 then 0xFF with zero idle gap → exactly two done pulses, 10 bit times apart (±1 tick), data 8'h01 then 8'hFF.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and default parameters.
package uart_pkg;
    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int NB_STATE_DEF = 2;
    localparam int BAUD_DIV_DEF = 163;
    localparam int NB_DIV_DEF   = 8;
    localparam int OVERSAMPLE   = 16;
    typedef enum logic [NB_STATE_DEF-1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;
endpackage

// File: rtl/uart_rx_bg_baud_rate_gen.sv
// baud_rate_gen: free-running divider emitting a one-cycle oversample tick.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int NB_DIV   = NB_DIV_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);
    logic [NB_DIV-1:0] r_cnt;
    assign o_tick = (r_cnt == NB_DIV'(BAUD_DIV - 1));
    always_ff @(posedge i_clock) begin
        r_cnt <= (i_reset || o_tick) ? '0 : r_cnt + NB_DIV'(1);
    end
endmodule

// File: rtl/uart_rx_bg.sv
// uart_rx_bg: 8N1 UART receiver, 16x oversampled mid-bit sampling, built-in baud tick.
module uart_rx_bg
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int NB_STATE = NB_STATE_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int NB_DIV   = NB_DIV_DEF
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);
    localparam int NB_S = $clog2(SB_TICK > OVERSAMPLE ? SB_TICK : OVERSAMPLE);
    localparam int NB_N = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NB_STATE-1:0] S_IDLE  = NB_STATE'(IDLE);
    localparam logic [NB_STATE-1:0] S_START = NB_STATE'(START);
    localparam logic [NB_STATE-1:0] S_DATA  = NB_STATE'(DATA);
    localparam logic [NB_STATE-1:0] S_STOP  = NB_STATE'(STOP);

    logic                r_sync0, r_sync1;
    logic [NB_STATE-1:0] r_state;
    logic [NB_S-1:0]     r_s;
    logic [NB_N-1:0]     r_n;
    logic [DBIT-1:0]     r_b;
    logic                w_tick;
    logic                w_rx_s;

    assign w_rx_s = r_sync1;

    baud_rate_gen #(
        .BAUD_DIV(BAUD_DIV),
        .NB_DIV  (NB_DIV)
    ) u_baud (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= i_rx;
            r_sync1 <= r_sync0;
        end
    end

    // Outputs are registered: the STOP->IDLE transition loads them for the following cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_s            <= '0;
            r_n            <= '0;
            r_b            <= '0;
            o_rx_data      <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_s     <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_s == NB_S'(OVERSAMPLE / 2 - 1)) begin
                            r_state <= w_rx_s ? S_IDLE : S_DATA;
                            r_s     <= '0;
                            r_n     <= '0;
                        end else begin
                            r_s <= r_s + NB_S'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_s == NB_S'(OVERSAMPLE - 1)) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n == NB_N'(DBIT - 1)) r_state <= S_STOP;
                            else r_n <= r_n + NB_N'(1);
                        end else begin
                            r_s <= r_s + NB_S'(1);
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (r_s == NB_S'(SB_TICK - 1)) begin
                            r_state        <= S_IDLE;
                            o_rx_done_tick <= 1'b1;
                            o_rx_data      <= r_b;
                            o_frame_err    <= ~w_rx_s;
                        end else begin
                            r_s <= r_s + NB_S'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_bg.sv
// tb_uart_rx_bg: scoreboard bench driving directed serial frames into uart_rx_bg.
module tb_uart_rx_bg;
    localparam int BDIV = 4;
    localparam int BIT  = BDIV * 16;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_done_tick;
    logic       o_frame_err;

    exp_t exp_q[$];
    int   done_times[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    logic prev_done = 1'b0;

    uart_rx_bg #(.BAUD_DIV(BDIV), .NB_DIV(3)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .o_rx_data     (o_rx_data),
        .o_rx_done_tick(o_rx_done_tick),
        .o_frame_err   (o_frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (o_rx_done_tick) begin
            exp_t e;
            done_times.push_back(cyc);
            chk("single_cycle_pulse", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", {24'd0, o_rx_data}, {24'd0, e.data});
                chk("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
            end
        end
        prev_done <= o_rx_done_tick;
    end

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A bad stop bit is released early so the line is high before the next start check.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_q.push_back('{data: d, ferr: ~stop_ok});
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        if (stop_ok) begin
            drive(1'b1, BIT);
        end else begin
            drive(1'b0, BIT * 3 / 4);
            drive(1'b1, BIT / 4);
        end
    endtask

    initial begin
        logic [7:0] c3;
        int gap;
        c3 = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {24'd0, o_rx_data}, 32'd0);
        chk("reset_done", {31'd0, o_rx_done_tick}, 32'd0);
        chk("reset_ferr", {31'd0, o_frame_err}, 32'd0);
        i_reset = 1'b0;
        drive(1'b1, 2 * BIT);
        send_frame(8'hAA, 1'b1);
        drive(1'b1, BIT);
        drive(1'b0, BIT * 3 / 10);
        drive(1'b1, 2 * BIT);
        chk("glitch_hold", {24'd0, o_rx_data}, 32'h0000_00AA);
        send_frame(8'h55, 1'b0);
        drive(1'b1, BIT);
        send_frame(8'h0F, 1'b1);
        drive(1'b1, BIT);
        send_frame(8'h00, 1'b0);
        drive(1'b1, BIT);
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(c3[i], BIT);
        drive(c3[3], BIT / 2);
        i_reset = 1'b1;
        i_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk("midreset_data", {24'd0, o_rx_data}, 32'd0);
        chk("midreset_ferr", {31'd0, o_frame_err}, 32'd0);
        drive(1'b1, 2 * BIT);
        send_frame(8'h3C, 1'b1);
        drive(1'b1, BIT);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 3 * BIT);
        chk("done_count", done_times.size(), 32'd7);
        chk("queue_drained", exp_q.size(), 32'd0);
        if (done_times.size() >= 7) begin
            gap = done_times[6] - done_times[5];
            chk("b2b_spacing", {31'd0, (gap >= 10 * BIT - BDIV) && (gap <= 10 * BIT + BDIV)}, 32'd1);
        end else begin
            chk("b2b_spacing_missing", done_times.size(), 32'd7);
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
